// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter_if
// Description : Bundle of the register-file writeback handshake signals shared
//               between the two writeback requesters (ALU, memory) and the
//               write-port arbiter.
// Ports       : alu_valid/alu_reg/alu_data/alu_ready  - ALU writeback channel
//               mem_valid/mem_reg/mem_data/mem_ready  - memory writeback channel
//               rf_write_en/rf_dst_reg/rf_dst_data    - register-file write port
//               busy_mask                             - pending/in-flight dests
//               conflict_cnt                          - saturating conflict count
// Modports    : master - requester side (drives requests, observes results)
//               slave  - arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_write_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
);
    logic                   alu_valid;
    logic [ADDR_W-1:0]      alu_reg;
    logic [DATA_W-1:0]      alu_data;
    logic                   alu_ready;

    logic                   mem_valid;
    logic [ADDR_W-1:0]      mem_reg;
    logic [DATA_W-1:0]      mem_data;
    logic                   mem_ready;

    logic                   rf_write_en;
    logic [ADDR_W-1:0]      rf_dst_reg;
    logic [DATA_W-1:0]      rf_dst_data;

    logic [(2**ADDR_W)-1:0] busy_mask;
    logic [CNT_W-1:0]       conflict_cnt;

    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        input  alu_ready, mem_ready,
        input  rf_write_en, rf_dst_reg, rf_dst_data,
        input  busy_mask, conflict_cnt
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        output alu_ready, mem_ready,
        output rf_write_en, rf_dst_reg, rf_dst_data,
        output busy_mask, conflict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Round-robin arbiter sharing the single register-file write
//               port between the ALU (source 0) and memory (source 1)
//               writeback paths. The winning write appears on the write port
//               one cycle after its grant. Also exports a one-hot busy mask of
//               pending and in-flight destinations for RAW stall detection,
//               and a saturating count of cycles where both sources competed.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous reset, active-high
//               bus  - rf_write_arbiter_if.slave (see interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    rf_write_arbiter_if.slave   bus
);

    localparam int              c_nregs   = 2**ADDR_W;
    localparam logic            c_src_alu = 1'b0;
    localparam logic            c_src_mem = 1'b1;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic               r_last_grant;
    logic               r_write_en;
    logic [ADDR_W-1:0]  r_dst_reg;
    logic [DATA_W-1:0]  r_dst_data;
    logic [CNT_W-1:0]   r_conflict_cnt;

    logic               w_both_valid;
    logic               w_grant_alu;
    logic               w_grant_mem;
    logic               w_grant_any;
    logic [ADDR_W-1:0]  w_win_reg;
    logic [DATA_W-1:0]  w_win_data;
    logic [c_nregs-1:0] w_busy;

    // On a tie the source that did not win last time gets the port, so
    // neither requester ever waits more than one cycle.
    assign w_both_valid = bus.alu_valid && bus.mem_valid;
    assign w_grant_alu  = bus.alu_valid && (!bus.mem_valid || (r_last_grant == c_src_mem));
    assign w_grant_mem  = bus.mem_valid && (!bus.alu_valid || (r_last_grant == c_src_alu));
    assign w_grant_any  = w_grant_alu || w_grant_mem;

    assign w_win_reg    = w_grant_alu ? bus.alu_reg  : bus.mem_reg;
    assign w_win_data   = w_grant_alu ? bus.alu_data : bus.mem_data;

    assign bus.alu_ready = w_grant_alu;
    assign bus.mem_ready = w_grant_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant   <= c_src_mem;
            r_write_en     <= 1'b0;
            r_dst_reg      <= '0;
            r_dst_data     <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_grant_any) begin
                r_last_grant <= w_grant_mem ? c_src_mem : c_src_alu;
                r_dst_reg    <= w_win_reg;
                r_dst_data   <= w_win_data;
                // R0 is hard-wired zero: the request is consumed but no write
                // is issued to the register file.
                r_write_en   <= (w_win_reg != '0);
            end else begin
                r_write_en   <= 1'b0;
            end

            if (w_both_valid && (r_conflict_cnt != c_cnt_max)) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

    // Bit 0 stays clear because R0 can never be a RAW hazard.
    always_comb begin
        w_busy = '0;
        for (int i = 1; i < c_nregs; i++) begin
            w_busy[i] = (bus.alu_valid && (bus.alu_reg   == ADDR_W'(i))) ||
                        (bus.mem_valid && (bus.mem_reg   == ADDR_W'(i))) ||
                        (r_write_en    && (r_dst_reg     == ADDR_W'(i)));
        end
    end

    assign bus.busy_mask    = w_busy;
    assign bus.rf_write_en  = r_write_en;
    assign bus.rf_dst_reg   = r_dst_reg;
    assign bus.rf_dst_data  = r_dst_data;
    assign bus.conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: ALU (source 0) and memory (source 1).
- Arbitration is round-robin. The winning write is registered onto the register-file write port one cycle later.
- Also exports a 16-bit one-hot busy mask of registers with pending or in-flight writes, used by decode for RAW stall detection.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 4, register index width; register count = 2**ADDR_W (16).
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- alu_valid  in  1  ALU writeback request.
- alu_reg  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU writeback data.
- alu_ready  out  1  ALU request accepted this cycle.
- mem_valid  in  1  memory writeback request.
- mem_reg  in  ADDR_W  memory destination register.
- mem_data  in  DATA_W  memory writeback data.
- mem_ready  out  1  memory request accepted this cycle.
- rf_write_en  out  1  register-file write enable.
- rf_dst_reg  out  ADDR_W  register-file write index.
- rf_dst_data  out  DATA_W  register-file write data.
- busy_mask  out  2**ADDR_W  one-hot OR of pending and in-flight destinations.
- conflict_cnt  out  CNT_W  cycles in which both sources were valid (saturating).

Behaviour:
- Reset (async, immediate):
  - rf_write_en=0, rf_dst_reg=0, rf_dst_data=0, conflict_cnt=0.
  - last_grant=1 (MEM), so ALU wins the first tie.
  - An in-flight registered write is dropped; the requester is not re-notified.
- Handshake:
  - A transfer occurs when valid && ready.
  - A requester holds valid, reg and data stable until ready.
  - ready is combinational from the valids and last_grant. It is never asserted without the matching valid.
- Arbitration (combinational, one grant per cycle):
  - Only alu_valid: grant ALU.
  - Only mem_valid: grant MEM.
  - Both valid: grant the source that is not last_grant.
  - Neither valid: no grant; last_grant unchanged.
  - last_grant updates to the granted source on every grant.
  - Maximum wait for any requester is 1 cycle.
- Output register (latency 1):
  - A grant in cycle N drives rf_dst_reg/rf_dst_data with the winner's reg/data in cycle N+1.
  - rf_write_en=1 in cycle N+1, except when the winner's reg==0: that request is accepted (ready=1) but rf_write_en=0, because R0 is read-only zero.
  - With no grant in cycle N, rf_write_en=0 in N+1 and rf_dst_reg/rf_dst_data hold their previous values.
  - Full throughput: one write per cycle.
- Same-destination conflict (both valid, same reg):
  - Writes are serialized in grant order; the later grant's data is the final register value.
  - No merging.
- busy_mask (combinational):
  - Bit i = (alu_valid && alu_reg==i) || (mem_valid && mem_reg==i) || (rf_write_en && rf_dst_reg==i).
  - Bit 0 is always 0.
- conflict_cnt:
  - Increments each cycle in which alu_valid && mem_valid.
  - Saturates at 2**CNT_W-1 and never wraps.
  - Cleared only by reset.
- No other internal state.

Test Plan:
- Reset, then both sources valid with alu_reg=3/0x1111 and mem_reg=5/0x2222:
  - Cycle 0: alu_ready=1, mem_ready=0.
  - Cycle 1: rf_write_en=1, reg 3, 0x1111; mem_ready=1.
  - Cycle 2: rf_write_en=1, reg 5, 0x2222.
  - conflict_cnt=1.
- Both sources held valid for 6 cycles:
  - Grants alternate ALU, MEM, ALU, ...
  - rf_write_en=1 every cycle from cycle 1.
  - conflict_cnt increments on each cycle where both are valid (valid drops once a source's final request is accepted).
- alu_valid with alu_reg=0, data 0xFFFF:
  - alu_ready=1.
  - Next cycle rf_write_en=0.
  - busy_mask[0]=0 throughout.
- Both sources valid with reg 7, ALU 0xAAAA and MEM 0xBBBB, after a prior MEM grant:
  - ALU writes first, then MEM.
  - Final model value of R7 = 0xBBBB.
  - busy_mask[7]=1 until the cycle after the second write.
- Assert rst mid-stream while rf_write_en=1:
  - Outputs clear immediately without waiting for a clock edge.
  - After release, a simultaneous request is granted to ALU.
- Force 300 conflict cycles:
  - conflict_cnt saturates at 255.
